// File: rtl/imm_decode_stage_if.sv
// Fetch->decode->execute handshake bundle for imm_decode_stage.
// The stage uses the slave modport; the producer/consumer side uses master.
interface imm_decode_stage_if #(parameter int PC_WIDTH = 32);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [31:0]         out_instr;
  logic [31:0]         out_imm;
  logic [2:0]          out_fmt;
  logic                out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32I format classify + immediate build, one registered stage with valid/ready.
// Define SKID_BUFFER_EN to add a 1-entry skid register (registered in_ready).
module imm_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [31:0]         imm;
    logic [2:0]          fmt;
    logic                illegal;
  } entry_t;

  function automatic entry_t decode(input logic [PC_WIDTH-1:0] pc, input logic [31:0] i);
    entry_t e;
    e       = '0;
    e.pc    = pc;
    e.instr = i;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin
        e.fmt = FMT_U;
        e.imm = {i[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0100011: begin
        e.fmt = FMT_S;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: begin
        e.fmt = FMT_I;
        e.imm = {{20{i[31]}}, i[31:20]};
      end
      7'b0110011: e.fmt = FMT_R;
      default: begin
        e.fmt     = FMT_ILL;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  entry_t out_q, dec;
  logic   out_v, accept, drain;

  assign dec    = decode(bus.in_pc, bus.in_instr);
  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = out_v & bus.out_ready;

  assign bus.out_valid   = out_v;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

`ifdef SKID_BUFFER_EN
  entry_t skid_q;
  logic   skid_v;

  // skid_v implies out_v, so a full skid always has a stalled output ahead of it
  assign bus.in_ready = !skid_v & !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      skid_v <= 1'b0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end
`else
  assign bus.in_ready = (!out_v | bus.out_ready) & !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (accept) begin
      out_q <= dec;
      out_v <= 1'b1;
    end else if (drain) begin
      out_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboarded random + directed bench for imm_decode_stage.
// Works with and without SKID_BUFFER_EN.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0, errors = 0;
  exp_t q[$];
  exp_t prev, e_mon;
  logic prev_stall = 1'b0;

  imm_decode_stage_if #(.PC_WIDTH(32)) bus();

  imm_decode_stage #(.PC_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    return (v >= (32'd1 << (n - 1))) ? v - (32'd1 << n) : v;
  endfunction

  // Reference: field positions reassembled arithmetically, then sign-extended by subtraction
  function automatic exp_t model(input logic [31:0] u, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = u; e.imm = 32'd0; e.illegal = 1'b0; e.fmt = 3'd0;
    case (u[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = (u >> 12) << 12; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = sext(((u >> 31) << 20) | (((u >> 12) & 32'hFF) << 12) |
                     (((u >> 20) & 32'h1) << 11) | (((u >> 21) & 32'h3FF) << 1), 21);
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = sext(((u >> 31) << 12) | (((u >> 7) & 32'h1) << 11) |
                     (((u >> 25) & 32'h3F) << 5) | (((u >> 8) & 32'hF) << 1), 13);
      end
      7'h23: begin e.fmt = 3'd2; e.imm = sext(((u >> 25) << 5) | ((u >> 7) & 32'h1F), 12); end
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: begin e.fmt = 3'd1; e.imm = sext(u >> 20, 12); end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 13))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h63;
      4: op = 7'h23;  5: op = 7'h67;  6: op = 7'h03;  7: op = 7'h13;
      8: op = 7'h73;  9: op = 7'h0F;  10: op = 7'h33;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  // Stimulus side of the scoreboard: every accepted input queues its expected result
  always @(negedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready)
      q.push_back(model(bus.in_instr, bus.in_pc));
  end

  // Monitor: pops on output transfer; also checks hold-stable under backpressure
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_pc",    bus.out_pc,    prev.pc);
      chk("hold_instr", bus.out_instr, prev.instr);
      chk("hold_imm",   bus.out_imm,   prev.imm);
      chk("hold_fmt",   32'(bus.out_fmt), 32'(prev.fmt));
    end
    if (reset || flush) begin
      q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: output instr %h with empty scoreboard", bus.out_instr);
      end else begin
        e_mon = q.pop_front();
        chk("sb_pc",      bus.out_pc,    e_mon.pc);
        chk("sb_instr",   bus.out_instr, e_mon.instr);
        chk("sb_imm",     bus.out_imm,   e_mon.imm);
        chk("sb_fmt",     32'(bus.out_fmt),     32'(e_mon.fmt));
        chk("sb_illegal", 32'(bus.out_illegal), 32'(e_mon.illegal));
      end
    end
    prev_stall  = bus.out_valid && !bus.out_ready && !reset && !flush;
    prev.pc     = bus.out_pc;
    prev.instr  = bus.out_instr;
    prev.imm    = bus.out_imm;
    prev.fmt    = bus.out_fmt;
    prev.illegal = bus.out_illegal;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = bus.in_pc + 32'd4;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},   32'(bus.out_valid), 32'd0);
    chk({tag, "_pc"},      bus.out_pc,    32'd0);
    chk({tag, "_instr"},   bus.out_instr, 32'd0);
    chk({tag, "_imm"},     bus.out_imm,   32'd0);
    chk({tag, "_fmt"},     32'(bus.out_fmt),     32'd0);
    chk({tag, "_illegal"}, 32'(bus.out_illegal), 32'd0);
  endtask

  int  nacc;
  int  exp_acc;
  logic took;

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'h100; bus.out_ready = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk_zero("reset");
    cyc();
    reset = 1'b0;

    // addi x1,x0,-1 : one-cycle latency
    bus.out_ready = 1'b1;
    offer(32'hFFF00093);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_imm",   bus.out_imm, 32'hFFFFFFFF);
    chk("t1_fmt",   32'(bus.out_fmt), 32'd1);

    // back-to-back: beq then sw, then lui then illegal
    offer(32'hFE000EE3); cyc();
    offer(32'hFE112C23);
    @(negedge clk);
    chk("t2_beq_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("t2_beq_fmt", 32'(bus.out_fmt), 32'd3);
    cyc();
    offer(32'h123450B7);
    @(negedge clk);
    chk("t2_sw_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_sw_imm",   bus.out_imm, 32'hFFFFFFF8);
    chk("t2_sw_fmt",   32'(bus.out_fmt), 32'd2);
    cyc();
    offer(32'h0000007F);
    @(negedge clk);
    chk("t3_lui_imm", bus.out_imm, 32'h12345000);
    chk("t3_lui_fmt", 32'(bus.out_fmt), 32'd4);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_ill_fmt", 32'(bus.out_fmt), 32'd7);
    chk("t3_ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("t3_ill_imm", bus.out_imm, 32'd0);
    cyc();

    // backpressure for 3 cycles with input pending
    bus.out_ready = 1'b0;
    offer(32'h00500113); cyc();
    offer(32'h00A00193);
    nacc = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_instr", bus.out_instr, 32'h00500113);
      took = bus.in_valid && bus.in_ready;
      if (took) nacc++;
      cyc();
      if (took) offer(32'h00F00213);
    end
`ifdef SKID_BUFFER_EN
    exp_acc = 1;
`else
    exp_acc = 0;
`endif
    @(negedge clk);
    chk("t4_accepts", nacc, exp_acc);
    chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("t4_drained", q.size(), 0);

    // flush with entries held; the flush-cycle offer must vanish
    cyc();
    bus.out_ready = 1'b0;
    offer(32'h00100293); cyc();
    offer(32'h00200313); cyc();
    offer(32'h00300393); flush = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_flush", 32'(bus.in_ready), 32'd0);
    cyc();
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid_cleared", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("t5_no_emit", 32'(bus.out_valid), 32'd0);

    // reset mid-stall
    cyc();
    bus.out_ready = 1'b0;
    offer(32'h00400413); cyc();
    offer(32'h00500493); cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk_zero("t6_reset");
    bus.out_ready = 1'b1;
    offer(32'h00600513); cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_post_instr", bus.out_instr, 32'h00600513);
    cyc();

    // random traffic with backpressure and occasional flush
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      cyc();
      flush = ($urandom_range(0, 99) < 3);
      bus.out_ready = ($urandom_range(0, 99) < 60);
      if (took || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 99) < 70);
        bus.in_instr = rand_instr();
        bus.in_pc    = bus.in_pc + 32'd4;
      end
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) cyc();
    @(negedge clk);
    chk("final_drained", q.size(), 0);
    chk("final_idle", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
